// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: muldiv occupancy states, default unit
// latencies and the hard-wired zero register number.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/muldiv_occupancy.sv
// Occupancy tracker for the multi-cycle HI/LO multiply/divide unit: a down
// counter per op, busy flag, and the HI/LO write strobe on the last busy cycle.
module muldiv_occupancy
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_issue,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_hilo_we,
  output logic o_cnt_zero
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_t        r_state;
  md_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_load;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_load     = i_is_div ? DIV_LOAD : MULT_LOAD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Issue is only honoured when the unit is free or finishing this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_issue) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = w_load;
        end
      end
      BUSY: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (i_issue) begin
          w_cnt_nxt = w_load;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_busy     = (r_state == BUSY);
  assign o_hilo_we  = (r_state == BUSY) && w_cnt_zero;
  assign o_cnt_zero = w_cnt_zero;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller beside ID: load-use bubbles, branch flushes and
// waits on the multi-cycle HI/LO unit, with priority flush > load-use > muldiv.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_muldiv,
  input  logic       id_is_div,
  input  logic       id_uses_hilo,
  input  logic       ex_valid,
  input  logic       ex_memtoreg,
  input  logic       ex_regwrite,
  input  logic [4:0] ex_wbreg,
  input  logic       branch_taken,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_clr,
  output logic       idex_clr,
  output logic       md_busy,
  output logic       hilo_we
);

  logic w_lu_hz;
  logic w_md_hz;
  logic w_issue;
  logic w_md_busy;
  logic w_cnt_zero;

  assign w_lu_hz = id_valid && ex_valid && ex_memtoreg && ex_regwrite &&
                   (ex_wbreg != REG_ZERO) &&
                   ((id_uses_rs && (id_rs == ex_wbreg)) ||
                    (id_uses_rt && (id_rt == ex_wbreg)));

  assign w_md_hz = id_valid && (id_is_muldiv || id_uses_hilo) &&
                   w_md_busy && !w_cnt_zero;

  // A flushed or stalled muldiv in ID must not start the unit.
  assign w_issue = id_valid && id_is_muldiv && !branch_taken && !w_lu_hz && !w_md_hz;

  muldiv_occupancy #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_occ (
    .clk        (clk),
    .rst        (rst),
    .i_issue    (w_issue),
    .i_is_div   (id_is_div),
    .o_busy     (w_md_busy),
    .o_hilo_we  (hilo_we),
    .o_cnt_zero (w_cnt_zero)
  );

  assign md_busy = w_md_busy;

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_clr   = 1'b0;
    idex_clr   = 1'b0;
    if (branch_taken) begin
      ifid_clr = 1'b1;
      idex_clr = 1'b1;
    end else if (w_lu_hz || w_md_hz) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_clr   = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios plus random
// traffic, checked against a remaining-busy-cycles model of the muldiv unit.
module tb_hazard_stall_ctrl;

  localparam int MULT_N = 4;
  localparam int DIV_N  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       id_valid, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div, id_uses_hilo;
  logic [4:0] id_rs, id_rt, ex_wbreg;
  logic       ex_valid, ex_memtoreg, ex_regwrite, branch_taken;
  logic       pc_stall, ifid_stall, ifid_clr, idex_clr, md_busy, hilo_we;

  hazard_stall_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_muldiv (id_is_muldiv),
    .id_is_div    (id_is_div),
    .id_uses_hilo (id_uses_hilo),
    .ex_valid     (ex_valid),
    .ex_memtoreg  (ex_memtoreg),
    .ex_regwrite  (ex_regwrite),
    .ex_wbreg     (ex_wbreg),
    .branch_taken (branch_taken),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_clr     (ifid_clr),
    .idex_clr     (idex_clr),
    .md_busy      (md_busy),
    .hilo_we      (hilo_we)
  );

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       muldiv;
    logic       is_div;
    logic       hilo;
    logic       ex_valid;
    logic       ex_mem;
    logic       ex_rw;
    logic [4:0] ex_wb;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_clr;
    logic idex_clr;
    logic md_busy;
    logic hilo_we;
  } exp_t;

  exp_t q[$];
  int   rem   = 0;   // busy cycles left including the current one; 0 = unit free
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu, mdh, issue;
    id_valid     = s.id_valid;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_uses_rs   = s.uses_rs;
    id_uses_rt   = s.uses_rt;
    id_is_muldiv = s.muldiv;
    id_is_div    = s.is_div;
    id_uses_hilo = s.hilo;
    ex_valid     = s.ex_valid;
    ex_memtoreg  = s.ex_mem;
    ex_regwrite  = s.ex_rw;
    ex_wbreg     = s.ex_wb;
    branch_taken = s.br;

    lu  = s.id_valid && s.ex_valid && s.ex_mem && s.ex_rw && (s.ex_wb != 0) &&
          ((s.uses_rs && s.rs == s.ex_wb) || (s.uses_rt && s.rt == s.ex_wb));
    mdh = s.id_valid && (s.muldiv || s.hilo) && (rem > 1);
    e = '0;
    e.md_busy = (rem > 0);
    e.hilo_we = (rem == 1);
    if (s.br) begin
      e.ifid_clr = 1'b1;
      e.idex_clr = 1'b1;
    end else if (lu || mdh) begin
      e.pc_stall   = 1'b1;
      e.ifid_stall = 1'b1;
      e.idex_clr   = 1'b1;
    end
    q.push_back(e);

    issue = s.id_valid && s.muldiv && !s.br && !lu && !mdh;
    if (issue)        rem = s.is_div ? DIV_N : MULT_N;
    else if (rem > 0) rem = rem - 1;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    cyc++;
    apply(s);
  endtask

  // Monitor: every cycle that has a pending expectation is checked mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_stall, ifid_stall, ifid_clr, idex_clr, md_busy, hilo_we};
      total++;
      if (a !== e)begin
        bad++;
        $display("FAIL ctrl_outputs cycle=%0d {pc_stall,ifid_stall,ifid_clr,idex_clr,md_busy,hilo_we} got=%b exp=%b",
                 cyc, a, e);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    rst = 1'b1;
    apply(nop());
    void'(q.pop_front());
    step(nop());
    step(nop());
    rst = 1'b0;

    // Load-use on rs: one bubble, then the load has moved on
    s = nop();
    s.ex_valid = 1; s.ex_mem = 1; s.ex_rw = 1; s.ex_wb = 5'd5;
    s.id_valid = 1; s.rs = 5'd5; s.uses_rs = 1;
    step(s);
    s.ex_valid = 0; s.ex_mem = 0; s.ex_rw = 0;
    step(s);
    // No hazard on r0 or when rs is not read; hazard via rt
    s = nop();
    s.ex_valid = 1; s.ex_mem = 1; s.ex_rw = 1; s.ex_wb = 5'd0;
    s.id_valid = 1; s.rs = 5'd0; s.uses_rs = 1;
    step(s);
    s.ex_wb = 5'd5; s.rs = 5'd5; s.uses_rs = 0;
    step(s);
    s.rt = 5'd5; s.uses_rt = 1;
    step(s);
    step(nop());

    // MULT then dependent MFHI
    s = nop(); s.id_valid = 1; s.muldiv = 1;
    step(s);
    s = nop(); s.id_valid = 1; s.hilo = 1;
    repeat (5) step(s);
    step(nop());

    // DIV then a waiting MULT that issues back-to-back
    s = nop(); s.id_valid = 1; s.muldiv = 1; s.is_div = 1;
    step(s);
    s.is_div = 0;
    repeat (16) step(s);
    repeat (6) step(nop());

    // Branch beats load-use and blocks muldiv issue
    s = nop();
    s.ex_valid = 1; s.ex_mem = 1; s.ex_rw = 1; s.ex_wb = 5'd7;
    s.id_valid = 1; s.rs = 5'd7; s.uses_rs = 1; s.muldiv = 1; s.br = 1;
    step(s);
    step(nop());

    // Asynchronous reset in the middle of a divide
    s = nop(); s.id_valid = 1; s.muldiv = 1; s.is_div = 1;
    step(s);
    repeat (8) step(nop());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (md_busy !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_busy got=%b exp=0", md_busy);
    end
    total++;
    if (hilo_we !== 1'b0) begin
      bad++;
      $display("FAIL async_rst_hilo_we got=%b exp=0", hilo_we);
    end
    rem = 0;
    #1 rst = 1'b0;
    s = nop(); s.id_valid = 1; s.hilo = 1;
    step(s);
    repeat (3) step(nop());

    // Random traffic over a small register set for frequent collisions
    for (int i = 0; i < 3000; i++) begin
      s = nop();
      s.id_valid = ($urandom_range(0, 7) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.uses_rs  = 1'($urandom_range(0, 1));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.muldiv   = ($urandom_range(0, 5) == 0);
      s.is_div   = ($urandom_range(0, 3) == 0);
      s.hilo     = ($urandom_range(0, 3) == 0);
      s.ex_valid = 1'($urandom_range(0, 1));
      s.ex_mem   = 1'($urandom_range(0, 1));
      s.ex_rw    = ($urandom_range(0, 3) != 0);
      s.ex_wb    = 5'($urandom_range(0, 3));
      s.br       = ($urandom_range(0, 7) == 0);
      step(s);
    end

    step(nop());
    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
